// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants for the writeback arbiter
package regfile_wb_arbiter_pkg;

    // Requester slots on the writeback port
    localparam int REQ_ALU     = 0;
    localparam int REQ_MULTDIV = 1;
    localparam int REQ_EXC     = 2;

    // Register file geometry defaults
    localparam int NUM_REQ_DEF = 3;
    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 32;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - round-robin grant logic with rotating pointer
module regfile_wb_arbiter_rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_valid,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_any
);

    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_idx;
    logic               w_found;

    // Scan from the pointer upward (wrapping) and take the first valid requester;
    // nothing is granted while reset is held.
    always_comb begin
        logic [PTR_W:0]   v_sum;
        logic [PTR_W-1:0] v_pos;
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        v_sum   = '0;
        v_pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (v_sum >= (PTR_W+1)'(NUM_REQ)) begin
                v_sum = v_sum - (PTR_W+1)'(NUM_REQ);
            end
            v_pos = v_sum[PTR_W-1:0];
            if (!w_found && i_valid[v_pos]) begin
                w_found        = 1'b1;
                w_idx          = v_pos;
                w_grant[v_pos] = 1'b1;
            end
        end
        if (!rst_n) begin
            w_grant = '0;
            w_found = 1'b0;
        end
    end

    // Pointer moves just past the winner; idle cycles leave it in place.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PTR_W'(REQ_ALU);
        end else if (w_found) begin
            r_ptr <= (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign o_grant = w_grant;
    assign o_any   = w_found;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with pending-write scoreboard
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                      clock,
    input  logic                      ctrl_reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_reg,
    output logic [2**ADDR_W-1:0]      busy_mask,
    output logic                      ctrl_writeEnable,
    output logic [ADDR_W-1:0]         ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg
);

    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_any;
    logic [ADDR_W-1:0]    w_sel_reg;
    logic [DATA_W-1:0]    w_sel_data;
    logic [2**ADDR_W-1:0] w_busy_next;
    logic [2**ADDR_W-1:0] r_busy;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_wreg;
    logic [DATA_W-1:0]    r_wdata;

    regfile_wb_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clock   (clock),
        .rst_n   (ctrl_reset_n),
        .i_valid (req_valid),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    assign req_ready = w_grant;

    // One-hot grant lets the winner's slice be picked with a plain OR-mux.
    always_comb begin
        w_sel_reg  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_reg  = w_sel_reg  | req_reg[i*ADDR_W +: ADDR_W];
                w_sel_data = w_sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register the winning write; r0 writes are accepted but never enabled.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else if (w_any) begin
            r_we    <= (w_sel_reg != '0);
            r_wreg  <= w_sel_reg;
            r_wdata <= w_sel_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    // Clear on the completing write, then apply the reservation so a new
    // reservation to the same register survives the clear.
    always_comb begin
        w_busy_next = r_busy;
        if (r_we) begin
            w_busy_next[r_wreg] = 1'b0;
        end
        if (rsv_valid && (rsv_reg != '0)) begin
            w_busy_next[rsv_reg] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Pending-write scoreboard state.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign busy_mask        = r_busy;
    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_wreg;
    assign data_writeReg    = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic [NR-1:0] gnt;
        logic [AW-1:0] rg;
        logic [DW-1:0] dat;
    } exp_t;

    logic              clock = 1'b0;
    logic              ctrl_reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_reg;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_reg;
    logic [2**AW-1:0]  busy_mask;
    logic              ctrl_writeEnable;
    logic [AW-1:0]     ctrl_writeReg;
    logic [DW-1:0]     data_writeReg;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_exp[$];
    exp_t pend;
    bit   pend_v = 1'b0;

    always #5 clock = ~clock;

    regfile_wb_arbiter dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .req_valid        (req_valid),
        .req_reg          (req_reg),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .rsv_valid        (rsv_valid),
        .rsv_reg          (rsv_reg),
        .busy_mask        (busy_mask),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i, input logic [AW-1:0] rg, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_reg[i*AW +: AW]   = rg;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic expect_grant(input int i, input logic [AW-1:0] rg, input logic [DW-1:0] d);
        exp_t e;
        e.gnt = NR'(1) << i;
        e.rg  = rg;
        e.dat = d;
        q_exp.push_back(e);
    endtask

    // Monitor: check last cycle's accepted write on the output register, then
    // pop the expectation for any transfer happening at the coming edge.
    always @(negedge clock) begin
        if (!ctrl_reset_n) begin
            pend_v = 1'b0;
            chk("ready_in_reset", 64'(req_ready), 64'(0));
        end else begin
            chk("write_enable", 64'(ctrl_writeEnable), 64'(pend_v && (pend.rg != '0)));
            if (pend_v && (pend.rg != '0)) begin
                chk("write_reg", 64'(ctrl_writeReg), 64'(pend.rg));
                chk("write_data", 64'(data_writeReg), 64'(pend.dat));
            end
            if ((req_valid & req_ready) != '0) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_grant", 64'(req_ready), 64'(0));
                    pend_v = 1'b0;
                end else begin
                    pend = q_exp.pop_front();
                    chk("grant", 64'(req_ready), 64'(pend.gnt));
                    pend_v = 1'b1;
                end
            end else begin
                pend_v = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_reset_n = 1'b0;
        req_valid    = '0;
        req_reg      = '0;
        req_data     = '0;
        rsv_valid    = 1'b0;
        rsv_reg      = '0;

        // Reset with everything requesting, then fairness over six grants
        for (int i = 0; i < NR; i++) drive(i, AW'(10 + i), DW'(32'hA0 + i));
        for (int c = 0; c < 6; c++) expect_grant(c % NR, AW'(10 + c % NR), DW'(32'hA0 + c % NR));
        repeat (2) @(negedge clock);
        chk("reset_we", 64'(ctrl_writeEnable), 64'(0));
        chk("reset_busy", 64'(busy_mask), 64'(0));
        chk("reset_ready", 64'(req_ready), 64'(0));
        chk("reset_wreg", 64'(ctrl_writeReg), 64'(0));
        @(posedge clock);
        #1 ctrl_reset_n = 1'b1;
        repeat (6) step();
        req_valid = '0;
        step();

        // Single write from the mult/div unit
        drive(REQ_MULTDIV, 5'd5, 32'hDEADBEEF);
        expect_grant(REQ_MULTDIV, 5'd5, 32'hDEADBEEF);
        step();
        req_valid = '0;
        repeat (2) step();

        // r0 write is accepted and dropped; reserving r0 is ignored
        drive(REQ_ALU, 5'd0, 32'h1234);
        expect_grant(REQ_ALU, 5'd0, 32'h1234);
        rsv_valid = 1'b1;
        rsv_reg   = 5'd0;
        step();
        req_valid = '0;
        rsv_valid = 1'b0;
        @(negedge clock);
        chk("r0_we", 64'(ctrl_writeEnable), 64'(0));
        chk("r0_busy", 64'(busy_mask), 64'(0));
        step();

        // Lone requester granted every cycle
        drive(REQ_EXC, 5'd20, 32'h55);
        repeat (3) expect_grant(REQ_EXC, 5'd20, 32'h55);
        repeat (3) step();
        req_valid = '0;
        step();

        // Reserve r7, then retire it with a write
        rsv_valid = 1'b1;
        rsv_reg   = 5'd7;
        step();
        rsv_valid = 1'b0;
        @(negedge clock);
        chk("busy7_set", 64'(busy_mask[7]), 64'(1));
        step();
        drive(REQ_EXC, 5'd7, 32'h77);
        expect_grant(REQ_EXC, 5'd7, 32'h77);
        step();
        req_valid = '0;
        @(negedge clock);
        chk("busy7_during_write", 64'(busy_mask[7]), 64'(1));
        step();
        @(negedge clock);
        chk("busy7_cleared", 64'(busy_mask), 64'(0));
        step();

        // Reservation colliding with the retiring write keeps the bit set
        rsv_valid = 1'b1;
        rsv_reg   = 5'd7;
        step();
        rsv_valid = 1'b0;
        drive(REQ_MULTDIV, 5'd7, 32'h88);
        expect_grant(REQ_MULTDIV, 5'd7, 32'h88);
        step();
        req_valid = '0;
        rsv_valid = 1'b1;
        rsv_reg   = 5'd7;
        @(negedge clock);
        chk("collide_we", 64'(ctrl_writeEnable), 64'(1));
        step();
        rsv_valid = 1'b0;
        @(negedge clock);
        chk("collide_busy7", 64'(busy_mask[7]), 64'(1));
        step();
        @(negedge clock);
        chk("collide_busy7_hold", 64'(busy_mask), 64'(32'h80));

        // Reset mid-operation: in-flight write and reservations are discarded
        step();
        rsv_valid = 1'b1;
        rsv_reg   = 5'd9;
        step();
        rsv_valid = 1'b0;
        drive(REQ_ALU, 5'd9, 32'h99);
        expect_grant(REQ_ALU, 5'd9, 32'h99);
        step();
        req_valid = '0;
        #2 ctrl_reset_n = 1'b0;
        #1;
        chk("midreset_we", 64'(ctrl_writeEnable), 64'(0));
        chk("midreset_busy", 64'(busy_mask), 64'(0));
        chk("midreset_data", 64'(data_writeReg), 64'(0));
        @(posedge clock);
        #1 ctrl_reset_n = 1'b1;

        // Pointer restarts at 0: requesters 1 and 2 are granted in that order
        drive(REQ_MULTDIV, 5'd3, 32'h31);
        drive(REQ_EXC, 5'd4, 32'h42);
        expect_grant(REQ_MULTDIV, 5'd3, 32'h31);
        expect_grant(REQ_EXC, 5'd4, 32'h42);
        repeat (2) step();
        req_valid = '0;
        repeat (2) step();

        chk("queue_drained", 64'(q_exp.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
